// File: rtl/fifo_frame_reader.sv
// Read-side consumer of the async FIFO: pops one DW-bit frame per request and
// streams it out LSB-first as BEATS beats of OUT_W bits on a valid/ready port.
module fifo_frame_reader #(
    parameter int DW    = 140,
    parameter int OUT_W = 28
) (
    input  logic             clk_out,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [DW-1:0]    data_from_fifo,
    output logic             fifo_r_enable,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [15:0]      frame_cnt,
    output logic             busy
);

    localparam int BEATS = DW / OUT_W;
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

    generate
        if (DW % OUT_W != 0) begin : g_bad_width
            $fatal(1, "fifo_frame_reader: DW must be a multiple of OUT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RD,
        LOAD,
        SEND
    } state_t;

    state_t          state;
    logic [DW-1:0]   shreg;
    logic [IW-1:0]   beat_idx;
    logic [IW-1:0]   next_idx;

    assign next_idx = beat_idx + 1'b1;

    // The current beat is always the low slice of the shift register.
    assign out_data = shreg[OUT_W-1:0];

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            fifo_r_enable <= 1'b0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            frame_cnt     <= '0;
            shreg         <= '0;
            beat_idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state         <= RD;
                        fifo_r_enable <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                RD: begin
                    // Pop pulse lasts exactly the RD cycle; read data arrives next cycle.
                    fifo_r_enable <= 1'b0;
                    state         <= LOAD;
                end
                LOAD: begin
                    shreg     <= data_from_fifo;
                    beat_idx  <= '0;
                    out_valid <= 1'b1;
                    out_last  <= (BEATS == 1);
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        shreg    <= shreg >> OUT_W;
                        beat_idx <= next_idx;
                        out_last <= (next_idx == LAST_IDX);
                        if (beat_idx == LAST_IDX) begin
                            frame_cnt <= frame_cnt + 16'd1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Self-checking bench for fifo_frame_reader: behavioural FIFO model, beat
// scoreboard, table of frames and hand-written corner-case sequences.
module tb_fifo_frame_reader;

    localparam int DW    = 140;
    localparam int OUT_W = 28;
    localparam int BEATS = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fifo_empty;
    logic [DW-1:0]    data_from_fifo = '0;
    logic             fifo_r_enable;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [15:0]      frame_cnt;
    logic             busy;

    always #5 clk = ~clk;

    fifo_frame_reader #(.DW(DW), .OUT_W(OUT_W)) dut (
        .clk_out        (clk),
        .rst_n          (rst_n),
        .fifo_empty     (fifo_empty),
        .data_from_fifo (data_from_fifo),
        .fifo_r_enable  (fifo_r_enable),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .frame_cnt      (frame_cnt),
        .busy           (busy)
    );

    // FIFO model: data appears the cycle after a sampled pop
    logic [DW-1:0] mem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int underflow = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_r_enable) begin
            if (rd_ptr == wr_ptr) underflow <= underflow + 1;
            else begin
                data_from_fifo <= mem[rd_ptr % 16];
                rd_ptr         <= rd_ptr + 1;
            end
        end
    end

    typedef struct {
        logic [DW-1:0]                 frame;
        logic [BEATS-1:0][OUT_W-1:0]   beats;
    } vec_t;

    vec_t tbl [5];
    logic [OUT_W:0] exp_q [$];
    int pulse_cyc [$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulse_cnt, valid_seen, busy_seen, first_valid_cyc;
    int base;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        pulse_cnt       = 0;
        valid_seen      = 0;
        busy_seen       = 0;
        first_valid_cyc = -1;
        pulse_cyc.delete();
    endtask

    task automatic push_frame(input int idx);
        mem[wr_ptr % 16] = tbl[idx].frame;
        wr_ptr++;
        for (int b = 0; b < BEATS; b++)
            exp_q.push_back({(b == BEATS - 1), tbl[idx].beats[b]});
    endtask

    // Scores the handshake about to occur, then advances to the next negedge.
    task automatic step();
        logic [OUT_W:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL beat: unexpected beat %0h, expected none", out_data);
            end else begin
                e = exp_q.pop_front();
                check("beat", {out_last, out_data}, e);
            end
        end
        @(negedge clk);
        cyc++;
        if (fifo_r_enable) begin
            pulse_cnt++;
            pulse_cyc.push_back(cyc);
        end
        if (out_valid) begin
            valid_seen++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (busy) busy_seen++;
    endtask

    task automatic run_until(input string name, input int target, input int budget);
        int n = 0;
        while (frame_cnt != 16'(target) && n < budget) begin
            step();
            n++;
        end
        check(name, frame_cnt, target);
    endtask

    task automatic wait_beat(input string name, input logic [OUT_W-1:0] val);
        int n = 0;
        while (!(out_valid && out_data == val) && n < 30) begin
            step();
            n++;
        end
        check(name, {out_valid, out_data}, {1'b1, val});
    endtask

    initial begin
        tbl[0] = '{140'h0000005_0000004_0000003_0000002_0000001,
                   {28'h0000005, 28'h0000004, 28'h0000003, 28'h0000002, 28'h0000001}};
        tbl[1] = '{140'h0F0F0F0_7654321_FEDCBA9_89ABCDE_1234567,
                   {28'h0F0F0F0, 28'h7654321, 28'hFEDCBA9, 28'h89ABCDE, 28'h1234567}};
        tbl[2] = '{140'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A,
                   {28'hA5A5A5A, 28'h5A5A5A5, 28'hA5A5A5A, 28'h5A5A5A5, 28'hA5A5A5A}};
        tbl[3] = '{140'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5,
                   {28'h5A5A5A5, 28'hA5A5A5A, 28'h5A5A5A5, 28'hA5A5A5A, 28'h5A5A5A5}};
        tbl[4] = '{140'h0000009_0000008_0000007_0000006_0000005,
                   {28'h0000009, 28'h0000008, 28'h0000007, 28'h0000006, 28'h0000005}};

        rst_n     = 1'b0;
        out_ready = 1'b1;
        clear_stats();
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_ren", fifo_r_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_data", out_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Empty FIFO: nothing may happen
        clear_stats();
        repeat (20) step();
        check("empty_pulses", pulse_cnt, 0);
        check("empty_valid", valid_seen, 0);
        check("empty_busy", busy_seen, 0);
        check("empty_cnt", frame_cnt, 0);

        // Single frame with full throughput
        clear_stats();
        push_frame(0);
        run_until("single_done", 1, 50);
        check("single_pulses", pulse_cnt, 1);
        check("single_latency", (pulse_cyc.size() > 0) ? first_valid_cyc - pulse_cyc[0] : -1, 2);
        check("single_valid_cycles", valid_seen, BEATS);
        check("single_busy", busy, 0);
        check("single_left", exp_q.size(), 0);

        // Backpressure on the third beat
        clear_stats();
        push_frame(0);
        wait_beat("bp_reach", 28'h3);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, 28'h3);
        end
        out_ready = 1'b1;
        run_until("bp_done", 2, 50);
        check("bp_pulses", pulse_cnt, 1);
        check("bp_left", exp_q.size(), 0);

        // Table of frames, one at a time
        for (int i = 0; i < 4; i++) begin
            clear_stats();
            base = int'(frame_cnt);
            push_frame(i);
            run_until("tbl_done", base + 1, 50);
            check("tbl_pulses", pulse_cnt, 1);
            check("tbl_left", exp_q.size(), 0);
        end

        // Back-to-back frames
        clear_stats();
        base = int'(frame_cnt);
        push_frame(2);
        push_frame(3);
        run_until("b2b_done", base + 2, 60);
        check("b2b_pulses", pulse_cnt, 2);
        check("b2b_spacing", (pulse_cyc.size() > 1) ? pulse_cyc[1] - pulse_cyc[0] : -1, BEATS + 3);
        check("b2b_left", exp_q.size(), 0);

        // Reset in the middle of a frame
        clear_stats();
        push_frame(0);
        wait_beat("mid_reach", 28'h3);
        rst_n = 1'b0;
        #1;
        check("mid_valid", out_valid, 0);
        check("mid_last", out_last, 0);
        check("mid_cnt", frame_cnt, 0);
        check("mid_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        wr_ptr = rd_ptr;
        rst_n  = 1'b1;
        push_frame(4);
        run_until("mid_after_done", 1, 50);
        check("mid_after_left", exp_q.size(), 0);
        check("underflow", underflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_frame_reader.md
Name: fifo_frame_reader

Overview:
Read-side consumer of the async_fifo on the clk_out domain. It pops one 140-bit frame at a time from the FIFO and serialises it into OUT_W-bit beats on a valid/ready stream toward the downstream datapath. It owns fifo_r_enable and drives it only as a one-cycle pop pulse. It also keeps a completed-frame counter for status and debug.

Parameters:
DW, 140, FIFO word width; must match async_fifo DW.
OUT_W, 28, output beat width; DW % OUT_W == 0 is required (elaboration-time check, $fatal otherwise).
BEATS, DW/OUT_W (=5), derived localparam; beats per frame.

Ports:
clk_out  input  1  read-domain clock; all logic on posedge.
rst_n  input  1  asynchronous active-low reset; synchronous deassertion is handled upstream.
fifo_empty  input  1  async_fifo empty flag (clk_out domain).
data_from_fifo  input  DW  async_fifo read data; valid the cycle after a sampled fifo_r_enable.
fifo_r_enable  output  1  pop request to async_fifo; single-cycle pulse.
out_data  output  OUT_W  current beat.
out_valid  output  1  beat valid.
out_ready  input  1  downstream accept.
out_last  output  1  high with the final beat (index BEATS-1) of a frame.
frame_cnt  output  16  frames fully delivered; wraps 16'hFFFF -> 0.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0, async): state=IDLE. fifo_r_enable, out_valid, out_last and busy=0. out_data=0, frame_cnt=0, shift register=0, beat_idx=0.
- FSM, one transition per posedge:
  - IDLE: if fifo_empty==0 -> RD, else stay.
  - RD: fifo_r_enable=1, decoded from state only with no combinational path from inputs. Always -> LOAD.
  - LOAD: shreg <= data_from_fifo, beat_idx <= 0, -> SEND.
  - SEND: out_valid=1, out_data=shreg[OUT_W-1:0], out_last=(beat_idx==BEATS-1).
    - On out_valid&&out_ready: shreg >>= OUT_W (zero fill) and beat_idx++.
    - If that handshake is on the last beat: frame_cnt++ and -> IDLE.
    - Without a handshake, out_data and out_last hold. Backpressure may last indefinitely.
- Latency: fifo_empty seen low at edge k -> fifo_r_enable high during cycle k..k+1 -> data captured at edge k+2 -> first beat valid right after edge k+2.
- Minimum frame period with out_ready held at 1: BEATS+3 cycles.
- Beat order is LSB first: beat i = frame[(i+1)*OUT_W-1 : i*OUT_W].
- Exactly one fifo_r_enable pulse per frame. fifo_r_enable is never high in IDLE, LOAD or SEND.
- fifo_empty is ignored outside IDLE. A read is issued only after empty was sampled low, and empty cannot rise without a pop, so no underflow pop is possible.
- fifo_empty toggling while the FSM is in SEND has no effect on the current frame.
- Reset mid-frame: the partial frame is discarded and outputs drop immediately (async). A FIFO word already popped is lost. Callers reset the FIFO together with this block.
- frame_cnt increments only on a completed last-beat handshake, never on pop.
- busy = (state != IDLE).

Test Plan:
- Single frame: reset, then FIFO holds {28'h5,28'h4,28'h3,28'h2,28'h1}, out_ready=1 -> exactly one 1-cycle fifo_r_enable pulse. out_data sequence is 1,2,3,4,5 on consecutive cycles starting 2 cycles after the pulse. out_last is high only with 28'h5. frame_cnt=1, busy back to 0.
- Backpressure: same frame, out_ready=0 for 3 cycles while beat 28'h3 is presented -> out_valid stays 1 and out_data holds 28'h3. No fifo_r_enable occurs, the remaining beats arrive in order, and frame_cnt=1.
- Empty FIFO: fifo_empty=1 for 20 cycles after reset -> fifo_r_enable, out_valid and busy stay 0, and frame_cnt=0.
- Back-to-back: two frames 140'hA5... and 140'h5A... written, out_ready=1 -> exactly two pulses with first-to-second spacing of 8 cycles (BEATS+3). 10 beats match both frames LSB first, and frame_cnt=2.
- Reset mid-frame: assert rst_n=0 during beat 3 of a frame -> out_valid=0, out_last=0 and frame_cnt=0 immediately. After release, with a new frame {28'h9,...,28'h5} in a fresh FIFO, the beats are 5..9 and frame_cnt=1.
